// File: rtl/mips_wb_pkg.sv
// Shared definitions for the register-file write-back path: MemtoReg source
// codes (also used by the main control unit), sequencer states and source helpers.
package mips_wb_pkg;

    localparam logic [3:0] SRC_ALUOUT    = 4'b0000;
    localparam logic [3:0] SRC_LOADSIZE  = 4'b0001;
    localparam logic [3:0] SRC_HI        = 4'b0010;
    localparam logic [3:0] SRC_LO        = 4'b0011;
    localparam logic [3:0] SRC_SHIFTREG  = 4'b0100;
    localparam logic [3:0] SRC_CONST227  = 4'b0101;
    localparam logic [3:0] SRC_SHIFTL16  = 4'b0110;
    localparam logic [3:0] SRC_B         = 4'b0111;
    localparam logic [3:0] SRC_SIGNEXT   = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SRC = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

    // Sources whose data arrives some unknown number of cycles after the request.
    function automatic logic is_gated(input logic [3:0] src);
        return src inside {SRC_LOADSIZE, SRC_HI, SRC_LO, SRC_SHIFTREG};
    endfunction

    function automatic logic is_legal(input logic [3:0] src);
        return src <= SRC_SIGNEXT;
    endfunction

endpackage

// File: rtl/wb_wait_timer.sv
// Wait-cycle counter for the write-back sequencer; flags the last allowed
// wait cycle so the controller can abort instead of waiting forever.
module wb_wait_timer
    import mips_wb_pkg::*;
#(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/wb_sequencer.sv
// Multi-cycle write-back controller: latches one request, holds the MemtoReg
// select, waits for a gated source, then issues a single register-file write.
module wb_sequencer
    import mips_wb_pkg::*;
#(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_src,
    input  logic [4:0] req_dest,
    input  logic       flush,
    input  logic       mem_ready,
    input  logic       hilo_busy,
    input  logic       shift_done,
    output logic [3:0] mem_to_reg,
    output logic [4:0] wb_addr,
    output logic       reg_write,
    output logic       done,
    output logic       err,
    output logic       busy,
    output logic [1:0] dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high and flush is low; req_ready is high only in IDLE.

    wb_state_e  state_q;
    logic [3:0] mem_to_reg_q;
    logic [4:0] wb_addr_q;
    logic       reg_write_q;
    logic       done_q;
    logic       err_q;

    logic       src_ok;
    logic       accept;
    logic       timer_clr;
    logic       timer_en;
    logic       timer_expired;

    always_comb begin
        src_ok = 1'b0;
        case (mem_to_reg_q)
            SRC_LOADSIZE:   src_ok = mem_ready;
            SRC_HI, SRC_LO: src_ok = !hilo_busy;
            SRC_SHIFTREG:   src_ok = shift_done;
            default:        src_ok = 1'b0;
        endcase
    end

    assign accept    = (state_q == ST_IDLE) && req_valid && !flush;
    assign timer_clr = accept;
    assign timer_en  = (state_q == ST_WAIT_SRC) && !src_ok && !flush;

    wb_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .CNT_W     (CNT_W)
    ) u_wait_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mem_to_reg_q <= '0;
            wb_addr_q    <= '0;
            reg_write_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            reg_write_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            if (flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (req_valid) begin
                            mem_to_reg_q <= req_src;
                            wb_addr_q    <= req_dest;
                            if (!is_legal(req_src)) begin
                                done_q <= 1'b1;
                                err_q  <= 1'b1;
                            end else if (is_gated(req_src)) begin
                                state_q <= ST_WAIT_SRC;
                            end else begin
                                state_q     <= ST_WRITE;
                                reg_write_q <= (req_dest != 5'd0);
                                done_q      <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_SRC: begin
                        if (src_ok) begin
                            state_q     <= ST_WRITE;
                            reg_write_q <= (wb_addr_q != 5'd0);
                            done_q      <= 1'b1;
                        end else if (timer_expired) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign mem_to_reg = mem_to_reg_q;
    assign wb_addr    = wb_addr_q;
    assign reg_write  = reg_write_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed scenarios plus random traffic, each cycle
// compared against a transaction-level model of the write-back rules.
module tb_wb_sequencer;

    localparam int WAIT_LIMIT   = 8;
    localparam int WAIT_LIMIT_4 = 4;
    localparam int CNT_W        = 8;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic [3:0] req_src;
    logic [4:0] req_dest;
    logic       flush;
    logic       mem_ready;
    logic       hilo_busy;
    logic       shift_done;

    logic       req_ready,   req_ready_4;
    logic [3:0] mem_to_reg,  mem_to_reg_4;
    logic [4:0] wb_addr,     wb_addr_4;
    logic       reg_write,   reg_write_4;
    logic       done,        done_4;
    logic       err,         err_4;
    logic       busy,        busy_4;
    logic [1:0] dbg_state,   dbg_state_4;

    always #5 clk = ~clk;

    wb_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dest(req_dest), .flush(flush), .mem_ready(mem_ready),
        .hilo_busy(hilo_busy), .shift_done(shift_done), .mem_to_reg(mem_to_reg),
        .wb_addr(wb_addr), .reg_write(reg_write), .done(done), .err(err),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Short-timeout instance, checked only in the timeout scenario.
    wb_sequencer #(.WAIT_LIMIT(WAIT_LIMIT_4), .CNT_W(CNT_W)) dut4 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_4),
        .req_src(req_src), .req_dest(req_dest), .flush(flush), .mem_ready(mem_ready),
        .hilo_busy(hilo_busy), .shift_done(shift_done), .mem_to_reg(mem_to_reg_4),
        .wb_addr(wb_addr_4), .reg_write(reg_write_4), .done(done_4), .err(err_4),
        .busy(busy_4), .dbg_state(dbg_state_4)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0] exp_q[$];          // expected writes as {select, address}
    bit         m_inflight;        // a request has been accepted and not finished
    bit         m_write_now;       // the accepted request is in its write cycle
    int         m_waited;          // cycles spent waiting for the source
    logic [3:0] e_sel;
    logic [4:0] e_addr;
    logic       e_rw, e_done, e_err;

    function automatic bit source_valid(input logic [3:0] src);
        if (src == 4'd1) return mem_ready;
        if (src == 4'd2 || src == 4'd3) return !hilo_busy;
        if (src == 4'd4) return shift_done;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_inflight  = 0;
        m_write_now = 0;
        m_waited    = 0;
        e_sel  = 4'd0;
        e_addr = 5'd0;
        e_rw   = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        e_rw   = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (flush) begin
            m_inflight  = 0;
            m_write_now = 0;
        end else if (m_write_now) begin
            m_write_now = 0;
            m_inflight  = 0;
        end else if (m_inflight) begin
            if (source_valid(e_sel)) begin
                m_write_now = 1;
                e_rw   = (e_addr != 5'd0);
                e_done = 1'b1;
            end else begin
                m_waited++;
                if (m_waited == WAIT_LIMIT) begin
                    m_inflight = 0;
                    e_done = 1'b1;
                    e_err  = 1'b1;
                end
            end
        end else if (req_valid) begin
            e_sel    = req_src;
            e_addr   = req_dest;
            m_waited = 0;
            if (req_src > 4'd8) begin
                e_done = 1'b1;
                e_err  = 1'b1;
            end else if (req_src >= 4'd1 && req_src <= 4'd4) begin
                m_inflight = 1;
            end else begin
                m_inflight  = 1;
                m_write_now = 1;
                e_rw   = (req_dest != 5'd0);
                e_done = 1'b1;
            end
        end
        if (e_rw) exp_q.push_back({e_sel, e_addr});
    endtask

    task automatic compare();
        logic [8:0] w;
        check_eq("reg_write",  16'(reg_write),  16'(e_rw));
        check_eq("done",       16'(done),       16'(e_done));
        check_eq("err",        16'(err),        16'(e_err));
        check_eq("busy",       16'(busy),       16'(m_inflight));
        check_eq("req_ready",  16'(req_ready),  16'(!m_inflight));
        check_eq("mem_to_reg", 16'(mem_to_reg), 16'(e_sel));
        check_eq("wb_addr",    16'(wb_addr),    16'(e_addr));
        if (reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_spurious_write", 16'(reg_write), 16'(0));
            end else begin
                w = exp_q.pop_front();
                check_eq("sb_write", 16'({mem_to_reg, wb_addr}), 16'(w));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive_req(input logic v, input logic [3:0] s, input logic [4:0] d);
        req_valid = v;
        req_src   = s;
        req_dest  = d;
    endtask

    task automatic idle_inputs();
        drive_req(1'b0, 4'd0, 5'd0);
        flush      = 1'b0;
        mem_ready  = 1'b0;
        hilo_busy  = 1'b0;
        shift_done = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mem_to_reg", 16'(mem_to_reg), 16'(0));
        check_eq("rst_wb_addr",    16'(wb_addr),    16'(0));
        check_eq("rst_reg_write",  16'(reg_write),  16'(0));
        check_eq("rst_done",       16'(done),       16'(0));
        check_eq("rst_err",        16'(err),        16'(0));
        check_eq("rst_busy",       16'(busy),       16'(0));
        check_eq("rst_req_ready",  16'(req_ready),  16'(1));
        reset_n = 1'b1;

        // Ungated source: write one cycle after acceptance.
        drive_req(1'b1, 4'd0, 5'd8);
        step();
        check_eq("ungated_rw",   16'(reg_write), 16'(1));
        check_eq("ungated_addr", 16'(wb_addr),   16'(8));
        check_eq("ungated_done", 16'(done),      16'(1));
        drive_req(1'b0, 4'd0, 5'd0);
        step();
        check_eq("ungated_idle", 16'(busy), 16'(0));

        // Gated load: mem_ready low five cycles, then high.
        drive_req(1'b1, 4'd1, 5'd9);
        step();
        drive_req(1'b0, 4'd0, 5'd0);
        repeat (5) step();
        mem_ready = 1'b1;
        step();
        check_eq("load_rw",  16'(reg_write),  16'(1));
        check_eq("load_sel", 16'(mem_to_reg), 16'(1));
        mem_ready = 1'b0;
        step();

        // Timeout on the WAIT_LIMIT=4 instance with hilo_busy stuck high.
        hilo_busy = 1'b1;
        drive_req(1'b1, 4'd2, 5'd10);
        step();
        drive_req(1'b0, 4'd0, 5'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("t4_reg_write", 16'(reg_write_4), 16'(0));
            check_eq("t4_done",      16'(done_4),      16'(i == 4));
            check_eq("t4_err",       16'(err_4),       16'(i == 4));
        end
        repeat (6) step();
        hilo_busy = 1'b0;
        repeat (3) step();

        // Illegal source, then a write aimed at $zero.
        drive_req(1'b1, 4'd11, 5'd5);
        step();
        check_eq("illegal_err", 16'(err), 16'(1));
        drive_req(1'b1, 4'd5, 5'd0);
        step();
        check_eq("zero_rw",   16'(reg_write), 16'(0));
        check_eq("zero_done", 16'(done),      16'(1));
        drive_req(1'b0, 4'd0, 5'd0);
        step();

        // Flush while waiting on the shifter.
        drive_req(1'b1, 4'd4, 5'd12);
        step();
        drive_req(1'b0, 4'd0, 5'd0);
        repeat (2) step();
        flush = 1'b1;
        step();
        check_eq("flush_busy", 16'(busy), 16'(0));
        check_eq("flush_done", 16'(done), 16'(0));
        flush = 1'b0;
        step();

        // Asynchronous reset in the middle of a wait.
        drive_req(1'b1, 4'd1, 5'd9);
        step();
        drive_req(1'b0, 4'd0, 5'd0);
        step();
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_busy",       16'(busy),       16'(0));
        check_eq("arst_mem_to_reg", 16'(mem_to_reg), 16'(0));
        check_eq("arst_wb_addr",    16'(wb_addr),    16'(0));
        check_eq("arst_reg_write",  16'(reg_write),  16'(0));
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // Back-to-back: the second request waits out the WRITE cycle.
        drive_req(1'b1, 4'd7, 5'd3);
        step();
        check_eq("b2b_ready_in_write", 16'(req_ready), 16'(0));
        drive_req(1'b1, 4'd8, 5'd4);
        step();
        step();
        check_eq("b2b_second_addr", 16'(wb_addr),   16'(4));
        check_eq("b2b_second_rw",   16'(reg_write), 16'(1));
        drive_req(1'b0, 4'd0, 5'd0);
        step();

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            req_valid  = ($urandom_range(0, 1) == 1);
            req_src    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                                     : 4'($urandom_range(0, 8));
            req_dest   = 5'($urandom_range(0, 31));
            flush      = ($urandom_range(0, 19) == 0);
            mem_ready  = ($urandom_range(0, 2) == 0);
            hilo_busy  = ($urandom_range(0, 9) < 7);
            shift_done = ($urandom_range(0, 2) == 0);
            step();
        end
        idle_inputs();
        repeat (3) step();
        check_eq("sb_pending", 16'(exp_q.size()), 16'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Multi-cycle write-back controller for the register-file write port.
- Accepts one write-back request per instruction, holds the MemtoReg select stable, and waits for the chosen source to become valid (memory load, Hi/Lo unit, shifter).
- Pulses reg_write for exactly one cycle, then reports completion.
- Sits between the main control FSM and the MemtoReg source mux and register file.

Parameters:
- WAIT_LIMIT, 64, maximum cycles spent in WAIT_SRC before abort with error; legal range 1..255.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  write-back request present.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_src  in  4  MemtoReg source code: 0000 AluOut, 0001 LoadSize, 0010 Hi, 0011 Lo, 0100 ShiftReg, 0101 constant 227, 0110 ShiftLeft16, 0111 B(rt), 1000 SignExtend; 1001-1111 are illegal.
- req_dest  in  5  destination register number.
- flush  in  1  synchronous abort of the request in flight.
- mem_ready  in  1  load data valid (gates source 0001).
- hilo_busy  in  1  mult/div unit busy (gates sources 0010 and 0011).
- shift_done  in  1  shifter result valid (gates source 0100).
- mem_to_reg  out  4  select to the MemtoReg mux.
- wb_addr  out  5  register-file write address.
- reg_write  out  1  register-file write enable.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: 1 = aborted (illegal source or timeout).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, mem_to_reg=0000, wb_addr=0, reg_write=0, done=0, err=0, busy=0, wait counter=0.
- States: IDLE, WAIT_SRC, WRITE.
- IDLE
  - req_ready=1.
  - On req_valid, latch req_src into mem_to_reg and req_dest into wb_addr; clear the counter.
  - Illegal source: no write; next state stays IDLE; done=1 and err=1 in the following cycle.
  - Source 0001, 0010, 0011 or 0100: go to WAIT_SRC.
  - Any other legal source: go to WRITE.
- WAIT_SRC
  - Each cycle, evaluate the gating condition for the latched source: 0001 needs mem_ready=1; 0010 and 0011 need hilo_busy=0; 0100 needs shift_done=1.
  - Condition true: go to WRITE.
  - Condition false: increment the counter. If counter == WAIT_LIMIT-1, go to IDLE with done=1 and err=1 on that transition, and no write.
- WRITE
  - reg_write=1 for this one cycle unless wb_addr==0; register $zero is never written, but done is still reported.
  - done=1, err=0 in this same cycle; next state IDLE.
- Output timing:
  - mem_to_reg and wb_addr are registered and stable from the cycle after acceptance through the WRITE cycle.
  - They hold their last value in IDLE and are not reset to 0 after completion.
  - Latency for ungated sources is 1 cycle from acceptance to reg_write.
  - Latency for gated sources is 1 + cycles until the condition, plus 1.
- flush
  - Has priority over every transition: go to IDLE, reg_write=0, done=0, no error report.
  - In IDLE, flush also blocks acceptance that cycle.
- Back-to-back: a new request is accepted in the first IDLE cycle after WRITE; there is no acceptance during the WRITE cycle itself.
- Reset asserted mid-operation: immediate return to reset values; the pending write is lost.

Decomposition:
- Package mips_wb_pkg holds:
  - The 4-bit source code constants (SRC_ALUOUT … SRC_SIGNEXT), shared with the main control unit.
  - The state encoding.
  - A function is_gated(src).
  - A function is_legal(src).
- One sub-module, wb_wait_timer: CNT_W-bit counter with clear, enable and an expired flag at WAIT_LIMIT-1.

Test Plan:
- Ungated source: request src=0000, dest=8 -> next cycle mem_to_reg=0000, wb_addr=8, reg_write=1, done=1, err=0; IDLE on the following cycle.
- Gated load: request src=0001, dest=9; mem_ready held low 5 cycles then high -> reg_write asserted exactly 1 cycle after mem_ready high, mem_to_reg=0001 stable throughout.
- Timeout: WAIT_LIMIT=4, src=0010 with hilo_busy stuck high -> done=1, err=1 after 4 WAIT_SRC cycles, reg_write never asserted.
- Illegal and $zero: src=1011 -> done=1, err=1, no write. Then src=0101, dest=0 -> done=1, err=0, reg_write=0.
- Flush and reset: flush in WAIT_SRC -> IDLE next cycle, no done. reset_n pulsed low mid-WAIT_SRC -> all outputs zero immediately, asynchronously.
- Back-to-back: two ungated requests on consecutive IDLE windows -> two single-cycle reg_write pulses with the correct wb_addr each; req_ready low during WRITE.
